ahbl_slave_decoder: RTL and testbench
=====================================

// Module: ahbl_slave_decoder
// PURPOSE
//  AHB-Lite address decoder and slave response mux sitting directly downstream of the bus mux.
//  Decodes the arbitrated address phase into one-hot HSEL for NS slaves.
//  Registers the data-phase owner and routes that slave's HRDATA/HREADYOUT/HRESP back upstream.
//  Contains a built-in default slave returning a two-cycle ERROR for unmapped active transfers.
// PARAMETERS
//  NS          4                                      number of slaves (1..8)
//  SLAVE_BASE  {32'h8000_0000,32'h4000_0000,32'h2000_0000,32'h0}  [NS-1:0][31:0] base per slave
//  SLAVE_MASK  {NS{32'hF000_0000}}                    [NS-1:0][31:0] compare mask per slave
// PORTS
//  HCLK        in   1     bus clock
//  HRESET      in   1     asynchronous, active-high reset
//  HADDR       in   32    address phase address from bus mux
//  HTRANS      in   2     transfer type from bus mux
//  HWRITE      in   1     direction, used only by error logging option
//  HREADY      out  1     muxed ready to bus mux; also broadcast to all slaves as their HREADY
//  HRESP       out  1     muxed response to bus mux (0 OKAY, 1 ERROR)
//  HRDATA      out  32    muxed read data to bus mux
//  HSEL        out  NS    one-hot slave select, address phase
//  HREADYOUT_S in   NS    per-slave HREADYOUT
//  HRESP_S     in   NS    per-slave HRESP
//  HRDATA_S    in   NS*32 per-slave read data, slave i at [32*i+:32]
// BEHAVIOUR
//  Decode (combinational)
//   - hit[i] = ((HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i]).
//   - HSEL[i] = HTRANS[1] & hit[i] & no lower-index hit. The lowest index wins on overlap.
//   - miss = HTRANS[1] & ~|hit.
//  Address phase acceptance
//   - The address phase is accepted on a rising HCLK edge when HREADY==1.
//   - The data-phase select register dsel (NS slaves + DEF + NONE) loads only on acceptance.
//   - If HSEL!=0, dsel loads that slave. If miss, dsel loads DEF. If IDLE/BUSY, dsel loads NONE.
//   - dsel holds while HREADY==0.
//  Response mux by dsel
//   - slave i: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=HRDATA_S slice i.
//   - NONE: HREADY=1, HRESP=0, HRDATA=0. This gives a zero-wait OKAY for IDLE/BUSY.
//   - DEF: driven by the default-slave FSM, with HRDATA=0.
//  Default-slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2
//   - DS_IDLE -> DS_ERR1 on an accepted miss.
//   - DS_ERR1 drives HREADY=0, HRESP=1. It always advances to DS_ERR2.
//   - DS_ERR2 drives HREADY=1, HRESP=1. This cycle accepts the next address phase.
//   - DS_ERR2 -> DS_ERR1 if the next accepted transfer is also a miss; otherwise -> DS_IDLE.
//   - Back-to-back unmapped transfers therefore give repeated 2-cycle ERRORs with no idle gap.
//  Latency: 0 added cycles. HSEL is combinational from HADDR; data phase is a pure mux of the selected slave.
//  Reset
//   - HRESET asserted (including mid-transfer) immediately forces dsel=NONE and FSM=DS_IDLE.
//   - Reset outputs: HREADY=1, HRESP=0, HRDATA=0, HSEL follows decode.
//   - An in-flight slave response is discarded.
//  Slave-side ERROR: HRESP_S passes through unmodified. Two-cycle compliance is the slave's duty.
// CONFIGURATION
//  AHBL_DECODE_ERRLOG_EN defined adds outputs ERR_COUNT[15:0] and ERR_ADDR[31:0]:
//   - ERR_COUNT is a saturating count of accepted misses (holds at 16'hFFFF).
//   - ERR_ADDR captures HADDR of the most recent accepted miss; bit 0 is replaced by HWRITE.
//   - Both clear to 0 on HRESET.
//  Undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING
//  1 Read NONSEQ 0x2000_0010, slave1 HREADYOUT=1, HRDATA_S1=0xDEAD_BEEF
//    -> HSEL=4'b0010 in addr phase; next cycle HRDATA=0xDEAD_BEEF, HREADY=1, HRESP=0.
//  2 NONSEQ 0x4000_0000, slave2 holds HREADYOUT=0 for 3 cycles, then 0x8000_0004 presented
//    -> HREADY=0 for 3 cycles; dsel stays slave2; HSEL=4'b1000 accepted only after HREADY=1.
//  3 NONSEQ 0x1000_0000 (unmapped)
//    -> HSEL=0; next cycle HREADY=0/HRESP=1; following cycle HREADY=1/HRESP=1; then OKAY.
//  4 Two consecutive unmapped NONSEQ (0x1000_0000, 0x3000_0000)
//    -> ERR1,ERR2,ERR1,ERR2 with no OKAY between; with ERRLOG, ERR_COUNT=2, ERR_ADDR[31:1]=0x3000_0000>>1.
//  5 HTRANS=IDLE at 0x8000_0000 -> HSEL=0; data phase HREADY=1, HRESP=0, HRDATA=0.
//  6 HRESET pulsed during DS_ERR1 -> same cycle HREADY=1, HRESP=0; FSM=DS_IDLE after release.

Source files
------------

// File: rtl/ahbl_slave_decoder.sv
// AHB-Lite address decoder and slave response mux with a built-in default slave.
// Decodes the address phase into one-hot HSEL, registers the data-phase owner
// and routes the owner's HRDATA/HREADYOUT/HRESP back upstream.
// Unmapped active transfers receive a two-cycle ERROR from the default slave.
// Optional feature macro: AHBL_DECODE_ERRLOG_EN adds ERR_COUNT / ERR_ADDR miss logging.
module ahbl_slave_decoder #(
    parameter int NS = 4,
    parameter logic [NS-1:0][31:0] SLAVE_BASE = {32'h8000_0000, 32'h4000_0000,
                                                 32'h2000_0000, 32'h0000_0000},
    parameter logic [NS-1:0][31:0] SLAVE_MASK = {NS{32'hF000_0000}}
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    output logic             HREADY,
    output logic             HRESP,
    output logic [31:0]      HRDATA,
    output logic [NS-1:0]    HSEL,
    input  logic [NS-1:0]    HREADYOUT_S,
    input  logic [NS-1:0]    HRESP_S,
    input  logic [NS*32-1:0] HRDATA_S
`ifdef AHBL_DECODE_ERRLOG_EN
    ,
    output logic [15:0]      ERR_COUNT,
    output logic [31:0]      ERR_ADDR
`endif
);

    // dsel encoding: 0..NS-1 = slave index, NS = default slave, NS+1 = nobody
    localparam int DW = $clog2(NS + 2);
    localparam logic [DW-1:0] DSEL_DEF  = DW'(NS);
    localparam logic [DW-1:0] DSEL_NONE = DW'(NS + 1);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;

    logic [NS-1:0] hit;
    logic          found;
    logic [DW-1:0] sel_idx;
    logic          miss;
    logic [DW-1:0] dsel;
    ds_t           ds_state, ds_next;
    logic          def_ready, def_resp;

    // HTRANS[0] (SEQ vs NONSEQ) does not affect decode; HWRITE only feeds the logger
    logic unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HWRITE};

    // Address decode: lowest-index hit wins, HSEL only for NONSEQ/SEQ
    always_comb begin
        hit     = '0;
        HSEL    = '0;
        found   = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < NS; i++) begin
            hit[i] = ((HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i]);
            if (hit[i] && !found) begin
                HSEL[i] = HTRANS[1];
                sel_idx = DW'(i);
                found   = 1'b1;
            end
        end
        miss = HTRANS[1] & ~found;
    end

    // Data-phase owner, loaded only when the address phase is accepted
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            dsel <= DSEL_NONE;
        else if (HREADY) begin
            if (HTRANS[1] && found)
                dsel <= sel_idx;
            else if (miss)
                dsel <= DSEL_DEF;
            else
                dsel <= DSEL_NONE;
        end
    end

    // Default-slave state register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            ds_state <= DS_IDLE;
        else
            ds_state <= ds_next;
    end

    // Default-slave next state; ERR2 accepts the next address so misses chain without a gap
    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: if (HREADY && miss) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = miss ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    // Default-slave outputs: stall with ERROR, then complete with ERROR
    always_comb begin
        def_ready = 1'b1;
        def_resp  = 1'b0;
        case (ds_state)
            DS_ERR1: begin def_ready = 1'b0; def_resp = 1'b1; end
            DS_ERR2: begin def_ready = 1'b1; def_resp = 1'b1; end
            default: ;
        endcase
    end

    // Response mux: NONE gives zero-wait OKAY, DEF from FSM, otherwise the owning slave
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (dsel == DSEL_DEF) begin
            HREADY = def_ready;
            HRESP  = def_resp;
        end
        for (int i = 0; i < NS; i++) begin
            if (dsel == DW'(i)) begin
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
                HRDATA = HRDATA_S[32*i +: 32];
            end
        end
    end

`ifdef AHBL_DECODE_ERRLOG_EN
    // Miss logger: saturating count and last miss address with HWRITE in bit 0
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ERR_COUNT <= '0;
            ERR_ADDR  <= '0;
        end else if (HREADY && miss) begin
            if (ERR_COUNT != 16'hFFFF)
                ERR_COUNT <= ERR_COUNT + 16'd1;
            ERR_ADDR <= {HADDR[31:1], HWRITE};
        end
    end
`endif

endmodule

// File: tb/tb_ahbl_slave_decoder.sv
// Self-checking bench for ahbl_slave_decoder: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_ahbl_slave_decoder;
    localparam int NS = 4;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic             HREADY, HRESP;
    logic [31:0]      HRDATA;
    logic [NS-1:0]    HSEL;
    logic [NS-1:0]    HREADYOUT_S, HRESP_S;
    logic [NS*32-1:0] HRDATA_S;
`ifdef AHBL_DECODE_ERRLOG_EN
    logic [15:0]      ERR_COUNT;
    logic [31:0]      ERR_ADDR;
`endif

    ahbl_slave_decoder dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .HSEL(HSEL),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S)
`ifdef AHBL_DECODE_ERRLOG_EN
        , .ERR_COUNT(ERR_COUNT), .ERR_ADDR(ERR_ADDR)
`endif
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the data phase (-1 nobody, -2 default slave, else slave)
    int          own = -1;
    int          err_left = 0;   // ERROR cycles remaining for the default slave
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;

    // Memory map by address top nibble
    function automatic int region_of(input logic [31:0] a);
        case (a[31:28])
            4'h0: return 0;
            4'h2: return 1;
            4'h4: return 2;
            4'h8: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check combinational outputs against the model, advance the model
    task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [NS-1:0] rdy,
                        input logic [NS-1:0] rsp, input logic [NS*32-1:0] d);
        int r;
        logic er, es;
        logic [31:0] ed;
        logic [NS-1:0] eh;
        @(negedge HCLK);
        HADDR = a; HTRANS = t; HREADYOUT_S = rdy; HRESP_S = rsp; HRDATA_S = d;
        HWRITE = 1'($urandom);
        #1;
        r = region_of(a);
        eh = '0;
        if (t[1] && r >= 0) eh[r] = 1'b1;
        if (own >= 0) begin
            er = rdy[own]; es = rsp[own]; ed = d[own*32 +: 32];
        end else if (own == -2) begin
            er = (err_left == 1); es = 1'b1; ed = '0;
        end else begin
            er = 1'b1; es = 1'b0; ed = '0;
        end
        chk("hsel",   32'(HSEL),   32'(eh));
        chk("hready", 32'(HREADY), 32'(er));
        chk("hresp",  32'(HRESP),  32'(es));
        chk("hrdata", HRDATA,      ed);
        @(posedge HCLK);
        if (own == -2 && err_left == 2) err_left = 1;
        if (er) begin
            if (!t[1]) own = -1;
            else if (r >= 0) own = r;
            else begin
                own = -2;
                err_left = 2;
                if (m_cnt < 16'hFFFF) m_cnt++;
                m_addr = {a[31:1], HWRITE};
            end
        end
    endtask

    logic [NS*32-1:0] rd;
    logic [NS-1:0]    all1;

    initial begin
        all1 = '1;
        rd = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1111};
        HRESET = 1'b1; HADDR = 32'h2000_0000; HTRANS = 2'b10; HWRITE = 1'b0;
        HREADYOUT_S = '1; HRESP_S = '0; HRDATA_S = rd;
        #1;
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp",  32'(HRESP),  32'd0);
        chk("rst_hrdata", HRDATA,      32'd0);
        chk("rst_hsel",   32'(HSEL),   32'h2);
        HTRANS = 2'b00;
        @(negedge HCLK); HRESET = 1'b0;

        // 1: read from slave 1
        step(32'h2000_0010, 2'b10, all1, '0, rd);
        step(32'h0000_0000, 2'b00, all1, '0, rd);
        // 2: slave 2 stalls 3 cycles while slave 3 address waits
        step(32'h4000_0000, 2'b10, all1, '0, rd);
        for (int i = 0; i < 3; i++) step(32'h8000_0004, 2'b10, 4'b1011, '0, rd);
        step(32'h8000_0004, 2'b10, all1, '0, rd);
        step(32'h0000_0000, 2'b00, all1, '0, rd);
        // 3: single unmapped transfer, explicit ERR1 check just after acceptance
        step(32'h1000_0000, 2'b10, all1, '0, rd);
        #1;
        chk("t3_err1_ready", 32'(HREADY), 32'd0);
        chk("t3_err1_resp",  32'(HRESP),  32'd1);
        step(32'h0000_0000, 2'b00, all1, '0, rd);
        step(32'h0000_0000, 2'b00, all1, '0, rd);
        // 4: back-to-back unmapped transfers
        step(32'h1000_0000, 2'b10, all1, '0, rd);
        step(32'h3000_0000, 2'b10, all1, '0, rd);
        step(32'h3000_0000, 2'b10, all1, '0, rd);
        step(32'h0000_0000, 2'b00, all1, '0, rd);
        step(32'h0000_0000, 2'b00, all1, '0, rd);
        step(32'h0000_0000, 2'b00, all1, '0, rd);
        // 5: IDLE at a mapped address
        step(32'h8000_0000, 2'b00, all1, '0, rd);
        step(32'h8000_0000, 2'b00, all1, '0, rd);
        // 6: reset pulsed while the default slave is in its first ERROR cycle
        step(32'h1000_0000, 2'b10, all1, '0, rd);
        #2;
        HRESET = 1'b1;
        #1;
        chk("t6_hready", 32'(HREADY), 32'd1);
        chk("t6_hresp",  32'(HRESP),  32'd0);
        chk("t6_hrdata", HRDATA,      32'd0);
        chk("t6_hsel",   32'(HSEL),   32'd0);
        own = -1; err_left = 0; m_cnt = 0; m_addr = '0;
        HTRANS = 2'b00;
        @(negedge HCLK); HRESET = 1'b0;
        step(32'h2000_0000, 2'b10, all1, '0, rd);
        step(32'h0000_0000, 2'b00, all1, '0, rd);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [NS-1:0] rr, rs;
            logic [31:0]   a;
            for (int k = 0; k < NS; k++) begin
                rr[k] = ($urandom_range(0, 3) != 0);
                rs[k] = ($urandom_range(0, 7) == 0);
                rd[k*32 +: 32] = $urandom;
            end
            a = $urandom;
            step(a, 2'($urandom_range(0, 3)), rr, rs, rd);
        end

`ifdef AHBL_DECODE_ERRLOG_EN
        #1;
        chk("err_count", 32'(ERR_COUNT), 32'(m_cnt));
        chk("err_addr",  ERR_ADDR,       m_addr);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
